ptp_event_io: RTL and testbench
===============================

Name: ptp_event_io

Overview:
Multi-channel successor to the single pps in/out block, sitting beside the RTC core in the rtc_clk domain.
- Captures timestamps on N_IN external event inputs, with selectable edge per channel, into a shared first-word-fall-through (FWFT) FIFO tagged with channel and edge.
- Generates N_OUT programmable periodic pulse trains (period, width, enable) phase-aligned to RTC second boundaries.

Parameters:
N_IN, 2, number of event capture inputs (1..8)
N_OUT, 2, number of periodic pulse outputs (1..8)
FIFO_AW, 3, timestamp FIFO address width; depth = 2**FIFO_AW
SYNC_STAGES, 2, input synchroniser flops (>=2)

Ports:
rtc_clk  in  1  RTC clock
rtc_rst_n  in  1  async reset, active low
tick_inc_i  in  32  tick increment, 6.26 unsigned ns
rtc_std_i  in  80  48b seconds + 32b ns
rtc_fns_i  in  16  fractional ns
evt_i  in  N_IN  async event inputs
evt_edge_i  in  2*N_IN  per channel: 00 off, 01 rise, 10 fall, 11 both
ts_pop_i  in  1  pop FIFO head
ts_valid_o  out  1  FIFO non-empty
ts_data_o  out  96  head {std[79:0], fns[15:0]}
ts_chan_o  out  3  head channel index
ts_edge_o  out  1  head edge, 1=rise 0=fall
ts_count_o  out  FIFO_AW+1  FIFO occupancy
ts_ovf_o  out  1  sticky overflow
ovf_clr_i  in  1  clear ts_ovf_o
out_en_i  in  N_OUT  per-output enable
out_period_i  in  32*N_OUT  period in ns
out_width_i  in  32*N_OUT  high width in ns
pulse_o  out  N_OUT  periodic pulse outputs

Behaviour:
Reset values:
- All outputs 0, FIFO empty, pending registers empty, next_start = 0.
- Reset mid-operation discards FIFO contents and any pulse in progress.

Capture path:
- evt_i passes SYNC_STAGES flops, then one delay flop; the edge is detected on the synchronised value.
- On a selected edge, {rtc_std_i, rtc_fns_i, edge} is loaded the same cycle into that channel's 1-entry pending register.
- Latency is fixed at SYNC_STAGES+1 rtc_clk; software corrects by (SYNC_STAGES+1)*tick.
- Edge on a channel whose pending register is still full: event dropped, ts_ovf_o set.

FIFO push and pop:
- One push per cycle; the lowest-index full pending register wins. Its pending register clears on push.
- Push while FIFO full and no pop: entry stays pending, no push occurs.
- Pop when empty: ignored.
- Pop and push together when full: both take effect, count unchanged.
- FWFT: head data is valid whenever ts_valid_o = 1 and updates the cycle after a pop.

Overflow flag:
- ovf_clr_i clears ts_ovf_o.
- Set has priority over clear in the same cycle.

Pulse path:
- adj_ns = (rtc_std_i[31:0] + tick_inc_i[31:26]) mod 1e9, registered. This gives a one-tick lookahead.
- Second wrap = adj_ns_reg < previous adj_ns_reg.
- Validity clamps:
  - Period valid range 1..1e9; an invalid period is treated as 1e9.
  - Width valid range 1..period-1; otherwise period>>1.
- Per-output registers: next_start and cur_end (32b).

Pulse FSM, per output, states IDLE / ARMED / HIGH / LOW:
- IDLE: pulse_o = 0. Go to ARMED on the first second wrap with out_en set.
- ARMED: on adj_ns_reg >= next_start, pulse_o <= 1, cur_end = next_start + width, next_start += period → HIGH.
- HIGH: on adj_ns_reg >= cur_end, pulse_o <= 0 → LOW.
- LOW:
  - if next_start >= 1e9, wait for second wrap, then next_start = 0 → ARMED;
  - else → ARMED.
- Any second wrap in HIGH or LOW forces next_start = 0, cur_end = min(cur_end, 1e9), state ARMED. The pulse is re-emitted at ns 0.
- out_en low in any state: pulse_o <= 0, next_start = 0 → IDLE.
- Period/width changes take effect at the next rise.

Optional Feature:
Macro PTP_EVT_DEGLITCH_EN.
- Defined: after synchronisation, the input level must be stable 3 consecutive cycles before an edge is recognised. Shorter glitches produce no event. Capture latency becomes SYNC_STAGES+3.
- Undefined: no filter, latency SYNC_STAGES+1.

Test Plan:
- Ch0 rise-only, evt_i[0] rises with rtc ns=100, tick 8ns, SYNC_STAGES=2 -> one entry, chan 0, edge 1, ns field 124.
- Ch0 and ch1 both edges, simultaneous toggles -> ch0 entry then ch1 entry on consecutive cycles; count 2; two pops -> ts_valid_o 0.
- 9 events into depth-8 FIFO, no pop, then a 10th on the same channel -> count 8, ts_ovf_o = 1, ninth entry held pending. One pop -> ninth pushed; ovf_clr_i -> flag 0.
- out0 period 250_000_000, width 1_000 -> four 1 µs pulses per second, rises at ns 0/250M/500M/750M (minus one tick lookahead). out_en dropped mid-pulse -> pulse_o 0 next cycle.
- Period 0, width 0 -> treated as 1e9 / 5e8: 1 PPS, 50% duty. Period 300_000_000 -> rises at 0/300M/600M/900M, then at ns 0 of next second.
- With PTP_EVT_DEGLITCH_EN: 2-cycle high glitch -> no entry; 4-cycle high -> entry with latency SYNC_STAGES+3.

Source files
------------

// File: rtl/ptp_event_io.sv
// ptp_event_io: multi-channel event timestamp capture and second-aligned periodic pulse generation (optional input deglitch filter: PTP_EVT_DEGLITCH_EN)
module ptp_event_io #(
  parameter int N_IN        = 2,
  parameter int N_OUT       = 2,
  parameter int FIFO_AW     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rtc_clk,
  input  logic                 rtc_rst_n,
  input  logic [31:0]          tick_inc_i,
  input  logic [79:0]          rtc_std_i,
  input  logic [15:0]          rtc_fns_i,
  input  logic [N_IN-1:0]      evt_i,
  input  logic [2*N_IN-1:0]    evt_edge_i,
  input  logic                 ts_pop_i,
  output logic                 ts_valid_o,
  output logic [95:0]          ts_data_o,
  output logic [2:0]           ts_chan_o,
  output logic                 ts_edge_o,
  output logic [FIFO_AW:0]     ts_count_o,
  output logic                 ts_ovf_o,
  input  logic                 ovf_clr_i,
  input  logic [N_OUT-1:0]     out_en_i,
  input  logic [32*N_OUT-1:0]  out_period_i,
  input  logic [32*N_OUT-1:0]  out_width_i,
  output logic [N_OUT-1:0]     pulse_o
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [31:0] NS_SEC = 32'd1_000_000_000;
  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} pstate_t;
  logic [N_IN-1:0] hit, rise, pend_v;
  logic [96:0] pend_d [N_IN];
  logic push, push_ok, pop, full, drop;
  logic [2:0] sel;
  logic [99:0] entry, head;
  logic [99:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr, rd;
  logic [FIFO_AW:0] cnt;
  logic [32:0] sum;
  logic [31:0] adj, adj_q, adj_p;
  logic wrap;

  for (genvar c = 0; c < N_IN; c++) begin : g_in
    logic [SYNC_STAGES-1:0] sync;
    logic filt, lvl;
    logic [1:0] ev;
`ifdef PTP_EVT_DEGLITCH_EN
    logic [1:0] hist;
    // last two synchronised samples; level accepted only after three equal samples
    always_ff @(posedge rtc_clk or negedge rtc_rst_n)
      if (!rtc_rst_n) hist <= '0;
      else hist <= {hist[0], sync[SYNC_STAGES-1]};
    assign lvl = (sync[SYNC_STAGES-1] == hist[0] && hist[0] == hist[1]) ? sync[SYNC_STAGES-1] : filt;
`else
    assign lvl = sync[SYNC_STAGES-1];
`endif
    // synchroniser, delayed level and registered rise/fall flags
    always_ff @(posedge rtc_clk or negedge rtc_rst_n)
      if (!rtc_rst_n) begin
        sync <= '0;
        filt <= 1'b0;
        ev   <= 2'b00;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], evt_i[c]};
        filt <= lvl;
        ev   <= {lvl & ~filt, ~lvl & filt};
      end
    assign hit[c]  = (ev[1] & evt_edge_i[2*c]) | (ev[0] & evt_edge_i[2*c+1]);
    assign rise[c] = ev[1];
  end

  // lowest-index full pending register wins the single push slot
  always_comb begin
    push  = 1'b0;
    sel   = '0;
    entry = '0;
    for (int i = N_IN - 1; i >= 0; i--)
      if (pend_v[i]) begin
        push  = 1'b1;
        sel   = 3'(i);
        entry = {pend_d[i][96:1], 3'(i), pend_d[i][0]};
      end
  end

  assign full    = cnt == (FIFO_AW+1)'(DEPTH);
  assign pop     = ts_pop_i && cnt != '0;
  assign push_ok = push && (!full || pop);
  assign drop    = |(hit & pend_v);

  // per-channel one-entry holding registers between edge detect and FIFO
  always_ff @(posedge rtc_clk or negedge rtc_rst_n)
    if (!rtc_rst_n) begin
      pend_v <= '0;
      for (int i = 0; i < N_IN; i++) pend_d[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (push_ok && sel == 3'(i)) pend_v[i] <= 1'b0;
        if (hit[i] && !pend_v[i]) begin
          pend_v[i] <= 1'b1;
          pend_d[i] <= {rtc_std_i, rtc_fns_i, rise[i]};
        end
      end
    end

  // sticky overflow; a new drop wins over a clear in the same cycle
  always_ff @(posedge rtc_clk or negedge rtc_rst_n)
    if (!rtc_rst_n) ts_ovf_o <= 1'b0;
    else ts_ovf_o <= drop ? 1'b1 : ovf_clr_i ? 1'b0 : ts_ovf_o;

  // FIFO pointers and occupancy
  always_ff @(posedge rtc_clk or negedge rtc_rst_n)
    if (!rtc_rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      wr  <= wr + FIFO_AW'(push_ok);
      rd  <= rd + FIFO_AW'(pop);
      cnt <= cnt + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
    end

  // FIFO storage; on full pop+push the write lands in the slot being vacated
  always_ff @(posedge rtc_clk)
    if (push_ok) mem[wr] <= entry;

  assign head       = mem[rd];
  assign ts_valid_o = cnt != '0;
  assign ts_data_o  = ts_valid_o ? head[99:4] : '0;
  assign ts_chan_o  = ts_valid_o ? head[3:1] : '0;
  assign ts_edge_o  = ts_valid_o & head[0];
  assign ts_count_o = cnt;

  assign sum = {1'b0, rtc_std_i[31:0]} + 33'(tick_inc_i[31:26]);
  assign adj = sum >= {1'b0, NS_SEC} ? 32'(sum - {1'b0, NS_SEC}) : sum[31:0];

  // one-tick lookahead nanoseconds and its previous value for wrap detection
  always_ff @(posedge rtc_clk or negedge rtc_rst_n)
    if (!rtc_rst_n) begin
      adj_q <= '0;
      adj_p <= '0;
    end else begin
      adj_q <= adj;
      adj_p <= adj_q;
    end

  assign wrap = adj_q < adj_p;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    pstate_t st, st_n, s0;
    logic [31:0] per_raw, wid_raw, per, wid, nxt, nxt_n, n0, ce, ce_n, c0;
    logic pul, pul_n;
    assign per_raw = out_period_i[32*o +: 32];
    assign wid_raw = out_width_i[32*o +: 32];
    assign per = (per_raw == '0 || per_raw > NS_SEC) ? NS_SEC : per_raw;
    assign wid = (wid_raw == '0 || wid_raw >= per) ? per >> 1 : wid_raw;
    assign s0  = wrap ? ARMED : st;
    assign n0  = wrap ? '0 : nxt;
    assign c0  = (wrap && ce > NS_SEC) ? NS_SEC : ce;
    // a second wrap re-arms from ns 0 so the first rise of each second lands on the wrap cycle
    always_comb begin
      st_n  = s0;
      nxt_n = n0;
      ce_n  = c0;
      pul_n = pul;
      if (!out_en_i[o]) begin
        st_n  = IDLE;
        nxt_n = '0;
        pul_n = 1'b0;
      end else if (s0 == ARMED && adj_q >= n0) begin
        st_n  = HIGH;
        pul_n = 1'b1;
        ce_n  = n0 + wid;
        nxt_n = n0 + per;
      end else if (s0 == HIGH && adj_q >= c0) begin
        st_n  = LOW;
        pul_n = 1'b0;
      end else if (s0 == LOW && n0 < NS_SEC) begin
        st_n  = ARMED;
      end
    end
    // pulse state registers
    always_ff @(posedge rtc_clk or negedge rtc_rst_n)
      if (!rtc_rst_n) begin
        st  <= IDLE;
        nxt <= '0;
        ce  <= '0;
        pul <= 1'b0;
      end else begin
        st  <= st_n;
        nxt <= nxt_n;
        ce  <= ce_n;
        pul <= pul_n;
      end
    assign pulse_o[o] = pul;
  end
endmodule

// File: tb/tb_ptp_event_io.sv
// tb_ptp_event_io: directed self-checking bench for ptp_event_io
module tb_ptp_event_io;
  localparam int N_IN = 2, N_OUT = 2, FIFO_AW = 3, SYNC_STAGES = 2;
`ifdef PTP_EVT_DEGLITCH_EN
  localparam int LAT = SYNC_STAGES + 3;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam logic [31:0] NS_SEC = 32'd1_000_000_000;
  logic rtc_clk = 1'b0, rtc_rst_n = 1'b0;
  logic [31:0] tick_inc_i = 32'd8 << 26;
  logic [79:0] rtc_std_i;
  logic [15:0] rtc_fns_i = 16'h1234;
  logic [N_IN-1:0] evt_i = '0;
  logic [2*N_IN-1:0] evt_edge_i = '0;
  logic ts_pop_i = 1'b0, ovf_clr_i = 1'b0;
  logic ts_valid_o, ts_edge_o, ts_ovf_o;
  logic [95:0] ts_data_o;
  logic [2:0] ts_chan_o;
  logic [FIFO_AW:0] ts_count_o;
  logic [N_OUT-1:0] out_en_i = '0, pulse_o;
  logic [32*N_OUT-1:0] out_period_i = '0, out_width_i = '0;
  logic [47:0] sec = 48'd5;
  logic [31:0] ns = 32'd4, ns_prev = '0, step = 32'd8, t0;
  logic [47:0] s0;
  logic [N_OUT-1:0] last_p = '0;
  logic [31:0] rises [N_OUT][16];
  logic [31:0] falls [N_OUT][16];
  int n_rise [N_OUT];
  int n_fall [N_OUT];
  int n_chk = 0, n_fail = 0;
  logic [31:0] e250 [6] = '{32'd0, 32'd250_000_000, 32'd500_000_000, 32'd750_000_000, 32'd0, 32'd250_000_000};
  logic [31:0] e300 [5] = '{32'd0, 32'd300_000_000, 32'd600_000_000, 32'd900_000_000, 32'd0};

  assign rtc_std_i = {sec, ns};

  ptp_event_io #(.N_IN(N_IN), .N_OUT(N_OUT), .FIFO_AW(FIFO_AW), .SYNC_STAGES(SYNC_STAGES)) dut (
    .rtc_clk(rtc_clk), .rtc_rst_n(rtc_rst_n), .tick_inc_i(tick_inc_i), .rtc_std_i(rtc_std_i),
    .rtc_fns_i(rtc_fns_i), .evt_i(evt_i), .evt_edge_i(evt_edge_i), .ts_pop_i(ts_pop_i),
    .ts_valid_o(ts_valid_o), .ts_data_o(ts_data_o), .ts_chan_o(ts_chan_o), .ts_edge_o(ts_edge_o),
    .ts_count_o(ts_count_o), .ts_ovf_o(ts_ovf_o), .ovf_clr_i(ovf_clr_i), .out_en_i(out_en_i),
    .out_period_i(out_period_i), .out_width_i(out_width_i), .pulse_o(pulse_o)
  );

  always #5 rtc_clk = ~rtc_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one clock: record pulse edges against the ns that produced them, then advance the RTC
  task automatic cyc();
    @(posedge rtc_clk);
    #1;
    for (int k = 0; k < N_OUT; k++) begin
      if (pulse_o[k] && !last_p[k]) begin
        if (n_rise[k] < 16) rises[k][n_rise[k]] = ns_prev;
        n_rise[k]++;
      end
      if (!pulse_o[k] && last_p[k]) begin
        if (n_fall[k] < 16) falls[k][n_fall[k]] = ns_prev;
        n_fall[k]++;
      end
    end
    last_p  = pulse_o;
    ns_prev = ns;
    if (ns + step >= NS_SEC) begin
      ns  = ns + step - NS_SEC;
      sec = sec + 48'd1;
    end else ns = ns + step;
  endtask

  task automatic clr_rec();
    for (int k = 0; k < N_OUT; k++) begin
      n_rise[k] = 0;
      n_fall[k] = 0;
      for (int i = 0; i < 16; i++) begin
        rises[k][i] = '1;
        falls[k][i] = '1;
      end
    end
  endtask

  task automatic pop1();
    ts_pop_i = 1'b1;
    cyc();
    ts_pop_i = 1'b0;
  endtask

  initial begin
    clr_rec();
    repeat (3) cyc();
    check("rst_valid", ts_valid_o, 0);
    check("rst_count", ts_count_o, 0);
    check("rst_ovf", ts_ovf_o, 0);
    check("rst_pulse", pulse_o, 0);
    check("rst_data", ts_data_o, 0);
    rtc_rst_n = 1'b1;
    while (ns != 32'd100) cyc();
    evt_edge_i = 4'b0001;
    evt_i[0] = 1'b1;
    repeat (LAT + 1) cyc();
    check("cap_early", ts_valid_o, 0);
    cyc();
    check("cap_valid", ts_valid_o, 1);
    check("cap_count", ts_count_o, 1);
    check("cap_data", ts_data_o, {48'd5, 32'd100 + 32'(LAT * 8), 16'h1234});
    check("cap_chan", ts_chan_o, 0);
    check("cap_edge", ts_edge_o, 1);
    pop1();
    check("cap_popped", ts_valid_o, 0);
    evt_i[0] = 1'b0;
    repeat (8) cyc();
    check("fall_ignored", ts_count_o, 0);

    evt_edge_i = 4'b1111;
    t0 = ns;
    evt_i = 2'b11;
    repeat (LAT + 2) cyc();
    check("both_cnt1", ts_count_o, 1);
    cyc();
    check("both_cnt2", ts_count_o, 2);
    check("both_chan0", ts_chan_o, 0);
    check("both_ns0", ts_data_o[47:16], t0 + 32'(LAT * 8));
    check("both_edge0", ts_edge_o, 1);
    pop1();
    check("both_chan1", ts_chan_o, 1);
    check("both_ns1", ts_data_o[47:16], t0 + 32'(LAT * 8));
    pop1();
    check("both_empty", ts_valid_o, 0);
    evt_i = 2'b00;
    repeat (LAT + 3) cyc();
    check("fall_cnt", ts_count_o, 2);
    check("fall_edge", ts_edge_o, 0);
    check("fall_chan", ts_chan_o, 0);
    pop1();
    pop1();

    evt_edge_i = 4'b0001;
    for (int i = 0; i < 9; i++) begin
      evt_i[0] = 1'b1;
      repeat (4) cyc();
      evt_i[0] = 1'b0;
      repeat (4) cyc();
    end
    repeat (4) cyc();
    check("full_cnt", ts_count_o, 8);
    check("full_noovf", ts_ovf_o, 0);
    evt_i[0] = 1'b1;
    repeat (4) cyc();
    evt_i[0] = 1'b0;
    repeat (8) cyc();
    check("ovf_cnt", ts_count_o, 8);
    check("ovf_set", ts_ovf_o, 1);
    pop1();
    check("pop_push_cnt", ts_count_o, 8);
    pop1();
    check("pop_cnt7", ts_count_o, 7);
    ovf_clr_i = 1'b1;
    cyc();
    ovf_clr_i = 1'b0;
    check("ovf_clr", ts_ovf_o, 0);
    repeat (7) pop1();
    check("drain_cnt", ts_count_o, 0);
    pop1();
    check("empty_pop_cnt", ts_count_o, 0);
    check("empty_pop_valid", ts_valid_o, 0);

    step = 32'd10_000_000;
    ns = 32'd500_000_000;
    out_period_i = {32'd0, 32'd250_000_000};
    out_width_i  = {32'd0, 32'd1_000};
    out_en_i = 2'b11;
    clr_rec();
    s0 = sec;
    while (!(sec == s0 + 48'd2 && ns == 32'd400_000_000)) cyc();
    check("p250_nrise", n_rise[0], 6);
    for (int i = 0; i < 6; i++) check($sformatf("p250_rise%0d", i), rises[0][i], e250[i]);
    check("p250_nfall", n_fall[0], 6);
    check("p250_fall0", falls[0][0], 32'd10_000_000);
    check("pps_nrise", n_rise[1], 2);
    check("pps_rise0", rises[1][0], 0);
    check("pps_rise1", rises[1][1], 0);
    check("pps_nfall", n_fall[1], 1);
    check("pps_fall0", falls[1][0], 32'd500_000_000);
    check("pps_high", pulse_o[1], 1);
    out_en_i = 2'b00;
    cyc();
    check("en_drop", pulse_o, 0);

    out_period_i = {32'd0, 32'd300_000_000};
    out_en_i = 2'b01;
    clr_rec();
    s0 = sec;
    while (!(sec == s0 + 48'd2 && ns == 32'd100_000_000)) cyc();
    check("p300_nrise", n_rise[0], 5);
    for (int i = 0; i < 5; i++) check($sformatf("p300_rise%0d", i), rises[0][i], e300[i]);
    check("p300_out1_idle", n_rise[1], 0);

`ifdef PTP_EVT_DEGLITCH_EN
    out_en_i = 2'b00;
    step = 32'd8;
    cyc();
    evt_i[0] = 1'b1;
    repeat (2) cyc();
    evt_i[0] = 1'b0;
    repeat (10) cyc();
    check("glitch_none", ts_count_o, 0);
    t0 = ns;
    evt_i[0] = 1'b1;
    repeat (4) cyc();
    evt_i[0] = 1'b0;
    repeat (4) cyc();
    check("dg_cnt", ts_count_o, 1);
    check("dg_ns", ts_data_o[47:16], t0 + 32'(LAT * 8));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
